// File: rtl/mem_access_ctrl_if.sv
// Signal bundle between the MEM stage, the memory access controller and the data bus.
// The controller binds the slave modport; the pipeline/bus environment binds master.
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // Handshakes: req_valid is held with op/addr/wdata stable until resp_valid
   // (one-cycle pulse) or flush. data_req is held with wr/size/addr/wdata
   // stable until data_addr_ok is seen in the same cycle. data_data_ok later
   // completes that single accepted transaction, with data_rdata valid alongside.
   logic              req_valid;
   logic [2:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              flush;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              exc_adel;
   logic              exc_ades;
   logic              stall;
   logic              data_req;
   logic              data_wr;
   logic [1:0]        data_size;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic              data_addr_ok;
   logic              data_data_ok;
   logic [DATA_W-1:0] data_rdata;

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, flush,
      input  data_addr_ok, data_data_ok, data_rdata,
      output resp_valid, resp_rdata, exc_adel, exc_ades, stall,
      output data_req, data_wr, data_size, data_addr, data_wdata
   );

   modport master (
      output req_valid, req_op, req_addr, req_wdata, flush,
      output data_addr_ok, data_data_ok, data_rdata,
      input  resp_valid, resp_rdata, exc_adel, exc_ades, stall,
      input  data_req, data_wr, data_size, data_addr, data_wdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: issues one SRAM-like bus transaction at a time,
// aligns/extends load data, replicates store data and flags misaligned accesses.
module mem_access_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   mem_access_ctrl_if.slave bus,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_DATA  = 3'd2,
      S_RESP  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t            state;
   logic [2:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_rep;
   logic [1:0]        req_size;
   logic              req_store;
   logic              req_misaligned;

   function automatic logic [1:0] op_size(input logic [2:0] op);
      case (op)
         3'b000, 3'b001, 3'b101: return 2'd0;
         3'b010, 3'b011, 3'b110: return 2'd1;
         default:                return 2'd2;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0]  op,
                                               input logic [1:0]  lo,
                                               input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      b = rd[{lo, 3'b000} +: 8];
      h = rd[{lo[1], 4'b0000} +: 16];
      case (op)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {24'h0, b};
         3'b010:  return {{16{h[15]}}, h};
         3'b011:  return {16'h0, h};
         3'b100:  return rd;
         default: return 32'h0;
      endcase
   endfunction

   always_comb begin
      req_size  = op_size(bus.req_op);
      req_store = bus.req_op[2] & (bus.req_op[1] | bus.req_op[0]);
      req_misaligned = ((req_size == 2'd1) && bus.req_addr[0]) ||
                       ((req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));
      case (req_size)
         2'd0:    wdata_rep = {4{bus.req_wdata[7:0]}};
         2'd1:    wdata_rep = {2{bus.req_wdata[15:0]}};
         default: wdata_rep = bus.req_wdata;
      endcase
   end

   assign bus.stall     = bus.req_valid & ~bus.resp_valid & ~bus.flush;
   assign bus.data_addr = addr_q;
   assign dbg_state     = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         op_q           <= 3'b000;
         addr_q         <= '0;
         bus.data_req   <= 1'b0;
         bus.data_wr    <= 1'b0;
         bus.data_size  <= 2'd0;
         bus.data_wdata <= '0;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
         bus.exc_adel   <= 1'b0;
         bus.exc_ades   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.req_valid && !bus.flush) begin
                  op_q           <= bus.req_op;
                  addr_q         <= bus.req_addr;
                  bus.data_wr    <= req_store;
                  bus.data_size  <= req_size;
                  bus.data_wdata <= wdata_rep;
                  if (req_misaligned) begin
                     // Address error completes without ever touching the bus.
                     bus.resp_valid <= 1'b1;
                     bus.resp_rdata <= '0;
                     bus.exc_adel   <= ~req_store;
                     bus.exc_ades   <= req_store;
                     state          <= S_RESP;
                  end else begin
                     bus.data_req <= 1'b1;
                     state        <= S_ADDR;
                  end
               end
            end
            S_ADDR: begin
               if (bus.flush) begin
                  bus.data_req <= 1'b0;
                  state        <= bus.data_addr_ok ? S_DRAIN : S_IDLE;
               end else if (bus.data_addr_ok) begin
                  bus.data_req <= 1'b0;
                  state        <= S_DATA;
               end
            end
            S_DATA: begin
               // A flush coinciding with data_ok has nothing left to drain.
               if (bus.data_data_ok) begin
                  if (bus.flush) begin
                     state <= S_IDLE;
                  end else begin
                     bus.resp_valid <= 1'b1;
                     bus.resp_rdata <= bus.data_wr ? '0 :
                                       load_extend(op_q, addr_q[1:0], bus.data_rdata);
                     state          <= S_RESP;
                  end
               end else if (bus.flush) begin
                  state <= S_DRAIN;
               end
            end
            S_RESP: begin
               bus.resp_valid <= 1'b0;
               bus.resp_rdata <= '0;
               bus.exc_adel   <= 1'b0;
               bus.exc_ades   <= 1'b0;
               state          <= S_IDLE;
            end
            S_DRAIN: begin
               if (bus.data_data_ok) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a delay-configurable bus responder, a response
// scoreboard fed at request time, and directed flush/reset/misalignment scenarios.
module tb_mem_access_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] dbg_state;

   mem_access_ctrl_if bus ();

   mem_access_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [33:0] exp_q[$];

   int          addr_delay = 0;
   int          data_delay = 1;
   logic [31:0] bus_rdata  = '0;
   int          req_cycles = 0;
   int          a_cnt = 0;
   int          d_cnt = 0;
   bit          d_pend = 1'b0;

   task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Bus responder: addr_ok after addr_delay waiting cycles, data_ok data_delay cycles later.
   initial begin
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = 1'b0;
      bus.data_rdata   = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.data_addr_ok = 1'b0;
         bus.data_data_ok = 1'b0;
         if (rst) begin
            a_cnt  = 0;
            d_pend = 1'b0;
         end else begin
            if (d_pend) begin
               d_cnt--;
               if (d_cnt <= 0) begin
                  bus.data_data_ok = 1'b1;
                  bus.data_rdata   = bus_rdata;
                  d_pend           = 1'b0;
               end
            end
            if (bus.data_req) begin
               req_cycles++;
               if (a_cnt >= addr_delay) begin
                  bus.data_addr_ok = 1'b1;
                  a_cnt  = 0;
                  d_pend = 1'b1;
                  d_cnt  = data_delay;
               end else begin
                  a_cnt++;
               end
            end else begin
               a_cnt = 0;
            end
         end
      end
   end

   // Scoreboard: every resp_valid pulse must match the oldest pending expectation.
   initial begin
      logic [33:0] exp;
      forever begin
         @(negedge clk);
         if (bus.resp_valid === 1'b1) begin
            check("resp_expected", 34'(exp_q.size() > 0), 34'(1));
            if (exp_q.size() > 0) begin
               exp = exp_q.pop_front();
               check("resp", {bus.exc_adel, bus.exc_ades, bus.resp_rdata}, exp);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic drive_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int ad, input int dd, input logic [33:0] exp_resp,
                         input logic [1:0] exp_size, input logic [31:0] exp_wdata,
                         input int exp_lat, input int exp_req);
      int lat;
      bit done;
      logic exp_wr;
      exp_wr     = (op >= 3'd5);
      addr_delay = ad;
      data_delay = dd;
      bus_rdata  = rdata;
      exp_q.push_back(exp_resp);
      @(posedge clk);
      #1;
      req_cycles = 0;
      drive_req(op, addr, wdata);
      lat  = 0;
      done = 1'b0;
      while (!done && lat < 64) begin
         @(negedge clk);
         if (bus.resp_valid === 1'b1) begin
            done = 1'b1;
            check({tag, "_stall_at_resp"}, 34'(bus.stall), 34'(0));
         end else begin
            lat++;
            check({tag, "_stall"}, 34'(bus.stall), 34'(1));
            if (bus.data_req === 1'b1) begin
               check({tag, "_bus_ctl"}, 34'({bus.data_wr, bus.data_size}), 34'({exp_wr, exp_size}));
               check({tag, "_bus_addr"}, 34'(bus.data_addr), 34'(addr));
               check({tag, "_bus_wdata"}, 34'(bus.data_wdata), 34'(exp_wdata));
            end
         end
      end
      check({tag, "_latency"}, 34'(lat), 34'(exp_lat));
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      check({tag, "_req_cycles"}, 34'(req_cycles), 34'(exp_req));
      @(negedge clk);
      check({tag, "_resp_pulse"}, 34'(bus.resp_valid), 34'(0));
      check({tag, "_idle"}, 34'(dbg_state), 34'(0));
   endtask

   initial begin
      logic [31:0] ra, rd;
      int ad, dd;
      rst = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_op    = 3'b000;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.flush     = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_state", 34'(dbg_state), 34'(0));
      check("reset_bus", 34'({bus.data_req, bus.data_wr, bus.data_size}), 34'(0));
      check("reset_resp", {bus.resp_valid, bus.exc_adel, bus.resp_rdata}, 34'(0));
      rst = 1'b0;

      run_op("lb",  3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 1, {2'b00, 32'hFFFF_FF80}, 2'd0, 32'h0, 3, 1);
      run_op("lhu", 3'b011, 32'h202, 32'h0, 32'h8001_7FFF, 2, 3, {2'b00, 32'h0000_8001}, 2'd1, 32'h0, 7, 3);
      run_op("sb",  3'b101, 32'h301, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 1, {2'b00, 32'h0}, 2'd0, 32'hA5A5_A5A5, 3, 1);
      run_op("lw_mis", 3'b100, 32'h402, 32'h0, 32'h0, 0, 1, {2'b10, 32'h0}, 2'd2, 32'h0, 1, 0);
      run_op("sh_mis", 3'b110, 32'h501, 32'h1234, 32'h0, 0, 1, {2'b01, 32'h0}, 2'd1, 32'h0, 1, 0);
      run_op("lh_hi", 3'b010, 32'h102, 32'h0, 32'h8001_7FFF, 0, 1, {2'b00, 32'hFFFF_8001}, 2'd1, 32'h0, 3, 1);
      run_op("lh_lo", 3'b010, 32'h100, 32'h0, 32'h8001_7FFF, 0, 1, {2'b00, 32'h0000_7FFF}, 2'd1, 32'h0, 3, 1);
      run_op("lbu", 3'b001, 32'h101, 32'h0, 32'h0000_9A00, 0, 1, {2'b00, 32'h0000_009A}, 2'd0, 32'h0, 3, 1);
      run_op("sh",  3'b110, 32'h502, 32'h1234_BEEF, 32'hFFFF_FFFF, 0, 1, {2'b00, 32'h0}, 2'd1, 32'hBEEF_BEEF, 3, 1);
      run_op("sw",  3'b111, 32'h704, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1, 2, {2'b00, 32'h0}, 2'd2, 32'hCAFE_F00D, 5, 2);

      // Flush while waiting in DATA: the late data_ok is drained, no response.
      addr_delay = 0;
      data_delay = 3;
      bus_rdata  = 32'h1111_2222;
      @(posedge clk); #1;
      drive_req(3'b100, 32'h700, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.flush     = 1'b1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("flush_data_state", 34'(dbg_state), 34'(2));
      check("flush_stall", 34'(bus.stall), 34'(0));
      @(posedge clk); #1;
      bus.flush = 1'b0;
      @(negedge clk);
      check("drain_state", 34'(dbg_state), 34'(4));
      check("drain_no_req", 34'(bus.data_req), 34'(0));
      @(negedge clk);
      check("drain_wait_data", 34'(dbg_state), 34'(4));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("drain_no_resp", 34'(bus.resp_valid), 34'(0));
      end
      check("drain_idle", 34'(dbg_state), 34'(0));
      run_op("lw_after_flush", 3'b100, 32'h600, 32'h0, 32'hDEAD_BEEF, 0, 1, {2'b00, 32'hDEAD_BEEF}, 2'd2, 32'h0, 3, 1);

      // Flush in ADDR before acceptance: request withdrawn.
      addr_delay = 5;
      data_delay = 1;
      @(posedge clk); #1;
      drive_req(3'b100, 32'h800, 32'h0);
      @(posedge clk); #1;
      bus.flush     = 1'b1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("flush_addr_req", 34'(bus.data_req), 34'(1));
      @(posedge clk); #1;
      bus.flush = 1'b0;
      @(negedge clk);
      check("flush_addr_drop", 34'(bus.data_req), 34'(0));
      check("flush_addr_idle", 34'(dbg_state), 34'(0));
      @(negedge clk);
      check("flush_addr_no_resp", 34'(bus.resp_valid), 34'(0));

      for (int i = 0; i < 6; i++) begin
         ra = 32'($urandom_range(0, 16383)) << 2;
         rd = $urandom;
         ad = $urandom_range(0, 2);
         dd = $urandom_range(1, 3);
         run_op("lw_rand", 3'b100, ra, 32'h0, rd, ad, dd, {2'b00, rd}, 2'd2, 32'h0, 3 + ad + dd - 1, ad + 1);
      end

      // Asynchronous reset while the request is on the bus.
      addr_delay = 10;
      @(posedge clk); #1;
      drive_req(3'b111, 32'hA04, 32'h5A5A_0F0F);
      @(posedge clk); #3;
      check("rst_pre_req", 34'(bus.data_req), 34'(1));
      rst = 1'b1;
      bus.req_valid = 1'b0;
      #1;
      check("rst_async_req", 34'(bus.data_req), 34'(0));
      check("rst_async_ctl", 34'({bus.data_wr, bus.data_size}), 34'(0));
      check("rst_async_addr", 34'(bus.data_addr), 34'(0));
      check("rst_async_wdata", 34'(bus.data_wdata), 34'(0));
      check("rst_async_resp", {bus.exc_adel, bus.exc_ades, bus.resp_rdata}, 34'(0));
      check("rst_async_state", 34'(dbg_state), 34'(0));
      @(negedge clk);
      rst = 1'b0;
      run_op("lw_after_rst", 3'b100, 32'hB00, 32'h0, 32'h0BAD_F00D, 0, 1, {2'b00, 32'h0BAD_F00D}, 2'd2, 32'h0, 3, 1);

      check("scoreboard_empty", 34'(exp_q.size()), 34'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
